// File: rtl/range_parse_pkg.sv
// Shared ASCII constants, parser state encoding and character helpers
// for the range line parser.
package range_parse_pkg;

  localparam logic [7:0] CH_NL   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  typedef enum logic [2:0] {
    LINE_START,
    LOW_FIRST,
    LOW,
    HIGH_FIRST,
    HIGH,
    SKIP,
    DONE
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/range_line_parser_dec_accum.sv
// Decimal accumulator: loads or shifts in one digit per enabled cycle and
// flags when the value produced by the incoming digit exceeds 2^ADDR_W-1.
module dec_accum #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [3:0]        digit,
  output logic [ADDR_W+3:0] acc,
  output logic              ovf
);

  localparam int ACC_W = ADDR_W + 4;
  localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {ADDR_W{1'b1}}};

  logic [ACC_W-1:0] acc_next;

  // acc never exceeds MAX_VAL when stepped, so acc*10+9 always fits in ACC_W.
  always_comb begin
    acc_next = (acc << 3) + (acc << 1) + ACC_W'(digit);
    if (load) begin
      acc_next = ACC_W'(digit);
    end
  end

  assign ovf = acc_next > MAX_VAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load || step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/range_line_parser.sv
// ASCII range-line parser feeding the fresh-range FIFO write port.
// Optional macro RANGE_SWAP_EN: write low>high lines with bounds swapped.
module range_line_parser
  import range_parse_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              fifo_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] range_low,
  output logic [ADDR_W-1:0] range_high,
  output logic              range_fresh,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  rec_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int ACC_W = ADDR_W + 4;

  state_t              state;
  logic                pend;
  logic                fresh_cur;
  logic [ADDR_W-1:0]   low_cur;
  logic [ACC_W-1:0]    acc;
  logic                ovf;
  logic                accept;
  logic                take;
  logic                is_dig;
  logic [3:0]          dig;
  logic                load;
  logic                step;
  logic                swap_needed;
  logic                inverted_err;
  logic                line_err;

  assign in_ready = (state == DONE) || !pend;
  assign wr_en    = pend && fifo_ready;
  assign accept   = in_valid && in_ready;
  // CR is consumed but otherwise invisible to the state machine.
  assign take     = accept && (in_data != CH_CR);
  assign is_dig   = is_digit(in_data);
  assign dig      = in_data[3:0];

  // acc is within range whenever HIGH sees the newline, so the full-width
  // compare is exact.
  assign swap_needed = ACC_W'(low_cur) > acc;

`ifdef RANGE_SWAP_EN
  assign inverted_err = 1'b0;
`else
  assign inverted_err = swap_needed;
`endif

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    if (take && is_dig) begin
      case (state)
        LINE_START, LOW_FIRST, HIGH_FIRST: load = 1'b1;
        LOW, HIGH:                         step = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    line_err = 1'b0;
    if (take) begin
      case (state)
        LINE_START: line_err = !((in_data == CH_NL) || (in_data == CH_BANG) || (is_dig && !ovf));
        LOW_FIRST, HIGH_FIRST: line_err = is_dig ? ovf : 1'b1;
        LOW:  line_err = is_dig ? ovf : (in_data != CH_DASH);
        HIGH: line_err = is_dig ? ovf : ((in_data == CH_NL) ? inverted_err : 1'b1);
        default: line_err = 1'b0;
      endcase
    end
  end

  dec_accum #(.ADDR_W(ADDR_W)) u_dec_accum (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .digit (dig),
    .acc   (acc),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LINE_START;
      pend        <= 1'b0;
      range_low   <= '0;
      range_high  <= '0;
      range_fresh <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      rec_count   <= '0;
      err_count   <= '0;
      fresh_cur   <= 1'b1;
      low_cur     <= '0;
    end else begin
      if (wr_en) begin
        pend      <= 1'b0;
        rec_count <= rec_count + CNT_W'(1);
      end

      if (line_err) begin
        err <= 1'b1;
        if (!(&err_count)) begin
          err_count <= err_count + CNT_W'(1);
        end
      end

      if (take) begin
        case (state)
          LINE_START: begin
            if (in_data == CH_NL) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (in_data == CH_BANG) begin
              fresh_cur <= 1'b0;
              state     <= LOW_FIRST;
            end else if (is_dig && !ovf) begin
              fresh_cur <= 1'b1;
              state     <= LOW;
            end else begin
              state <= SKIP;
            end
          end
          LOW_FIRST, HIGH_FIRST: begin
            if (is_dig && !ovf) begin
              state <= (state == LOW_FIRST) ? LOW : HIGH;
            end else if (in_data == CH_NL) begin
              state <= LINE_START;
            end else begin
              state <= SKIP;
            end
          end
          LOW: begin
            if (is_dig) begin
              if (ovf) state <= SKIP;
            end else if (in_data == CH_DASH) begin
              low_cur <= acc[ADDR_W-1:0];
              state   <= HIGH_FIRST;
            end else if (in_data == CH_NL) begin
              state <= LINE_START;
            end else begin
              state <= SKIP;
            end
          end
          HIGH: begin
            if (is_dig) begin
              if (ovf) state <= SKIP;
            end else if (in_data == CH_NL) begin
              if (!line_err) begin
                pend        <= 1'b1;
                range_fresh <= fresh_cur;
                range_low   <= swap_needed ? acc[ADDR_W-1:0] : low_cur;
                range_high  <= swap_needed ? low_cur : acc[ADDR_W-1:0];
              end
              state <= LINE_START;
            end else begin
              state <= SKIP;
            end
          end
          SKIP: begin
            if (in_data == CH_NL) state <= LINE_START;
          end
          DONE: state <= DONE;
          default: state <= SKIP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_range_line_parser.sv
// Scoreboard bench for range_line_parser: expected records are queued as
// lines are sent and compared when the DUT strobes wr_en.
module tb_range_line_parser;

  localparam int ADDR_W = 17;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    logic              fr;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              fifo_ready = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] range_low;
  logic [ADDR_W-1:0] range_high;
  logic              range_fresh;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  rec_count;
  logic [CNT_W-1:0]  err_count;

  int   checks = 0;
  int   errors = 0;
  rec_t sb[$];
  logic rand_ready = 1'b0;

  range_line_parser #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fifo_ready  (fifo_ready),
    .wr_en       (wr_en),
    .range_low   (range_low),
    .range_high  (range_high),
    .range_fresh (range_fresh),
    .done        (done),
    .err         (err),
    .rec_count   (rec_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      fifo_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every write is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got (%0d,%0d,%0d) expected no write",
                 range_low, range_high, range_fresh);
      end else begin
        rec_t e;
        e = sb.pop_front();
        if (range_low !== e.lo || range_high !== e.hi || range_fresh !== e.fr) begin
          errors++;
          $display("FAIL write_record got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   range_low, range_high, range_fresh, e.lo, e.hi, e.fr);
        end else begin
          $display("write (%0d,%0d,%0d) ok", range_low, range_high, range_fresh);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input int lo, input int hi, input logic fr);
    rec_t r;
    r.lo = ADDR_W'(lo);
    r.hi = ADDR_W'(hi);
    r.fr = fr;
    sb.push_back(r);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=%0b expected 1 for byte %02h", in_ready, b);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 9;
    if (wr_en !== 1'b0)       begin errors++; $display("FAIL reset_wr_en got %0b expected 0", wr_en); end
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
    if (range_low !== '0)     begin errors++; $display("FAIL reset_low got %0d expected 0", range_low); end
    if (range_high !== '0)    begin errors++; $display("FAIL reset_high got %0d expected 0", range_high); end
    if (range_fresh !== 1'b1) begin errors++; $display("FAIL reset_fresh got %0b expected 1", range_fresh); end
    if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %0b expected 0", done); end
    if (err !== 1'b0)         begin errors++; $display("FAIL reset_err got %0b expected 0", err); end
    if (rec_count !== '0)     begin errors++; $display("FAIL reset_rec_count got %0d expected 0", rec_count); end
    if (err_count !== '0)     begin errors++; $display("FAIL reset_err_count got %0d expected 0", err_count); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    fifo_ready = 1'b1;
    push(3, 5, 1'b1);
    push(10, 14, 1'b0);
    send_str("3-5\n!10-14\n\n");
    drain();
    checks += 4;
    if (done !== 1'b1)        begin errors++; $display("FAIL basic_done got %0b expected 1", done); end
    if (rec_count !== 16'd2)  begin errors++; $display("FAIL basic_rec_count got %0d expected 2", rec_count); end
    if (err !== 1'b0)         begin errors++; $display("FAIL basic_err got %0b expected 0", err); end
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL basic_done_ready got %0b expected 1", in_ready); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_ready = 1'b0;
    push(7, 9, 1'b1);
    send_str("7-9\n");
    push(1, 2, 1'b1);
    fork
      send_str("1-2\n");
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          checks += 3;
          if (wr_en !== 1'b0)    begin errors++; $display("FAIL stall_wr_en got %0b expected 0", wr_en); end
          if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b expected 0", in_ready); end
          if (range_low !== 17'd7 || range_high !== 17'd9) begin
            errors++;
            $display("FAIL stall_hold got (%0d,%0d) expected (7,9)", range_low, range_high);
          end
        end
        @(posedge clk);
        #1;
        fifo_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (rec_count !== 16'd2) begin errors++; $display("FAIL stall_rec_count got %0d expected 2", rec_count); end
    $display("test_backpressure done");
  endtask

  task automatic test_overflow();
    do_reset();
    fifo_ready = 1'b1;
    push(131071, 131071, 1'b1);
    push(0, 131071, 1'b1);
    send_str("131071-131071\n131072-1\n00-131071\n");
    drain();
    checks += 3;
    if (err !== 1'b1)         begin errors++; $display("FAIL ovf_err got %0b expected 1", err); end
    if (err_count !== 16'd1)  begin errors++; $display("FAIL ovf_err_count got %0d expected 1", err_count); end
    if (rec_count !== 16'd2)  begin errors++; $display("FAIL ovf_rec_count got %0d expected 2", rec_count); end
    $display("test_overflow done");
  endtask

  task automatic test_errors();
    logic [CNT_W-1:0] exp_err;
    do_reset();
    fifo_ready = 1'b1;
`ifdef RANGE_SWAP_EN
    push(2, 6, 1'b1);
    push(2, 6, 1'b1);
    exp_err = 16'd3;
`else
    push(2, 6, 1'b1);
    exp_err = 16'd4;
`endif
    send_str("a-3\n-4\n5-\n6-2\n2-6\n");
    drain();
    checks += 2;
    if (err_count !== exp_err) begin errors++; $display("FAIL errs_err_count got %0d expected %0d", err_count, exp_err); end
    if (err !== 1'b1)          begin errors++; $display("FAIL errs_err got %0b expected 1", err); end
    $display("test_errors done");
  endtask

  task automatic test_async_reset();
    do_reset();
    fifo_ready = 1'b0;
    send_str("7-9\n");
    @(posedge clk);
    #3;
    rst = 1'b1;
    fifo_ready = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL areset_wr_en got %0b expected 0", wr_en); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks += 6;
    if (rec_count !== '0)     begin errors++; $display("FAIL areset_rec_count got %0d expected 0", rec_count); end
    if (range_low !== '0)     begin errors++; $display("FAIL areset_low got %0d expected 0", range_low); end
    if (range_high !== '0)    begin errors++; $display("FAIL areset_high got %0d expected 0", range_high); end
    if (range_fresh !== 1'b1) begin errors++; $display("FAIL areset_fresh got %0b expected 1", range_fresh); end
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL areset_in_ready got %0b expected 1", in_ready); end
    if (done !== 1'b0)        begin errors++; $display("FAIL areset_done got %0b expected 0", done); end

    send_str("12-");
    #2;
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(1, 2, 1'b1);
    send_str("1-2\n");
    drain();
    checks += 2;
    if (err !== 1'b0)        begin errors++; $display("FAIL midline_err got %0b expected 0", err); end
    if (rec_count !== 16'd1) begin errors++; $display("FAIL midline_rec_count got %0d expected 1", rec_count); end
    $display("test_async_reset done");
  endtask

  task automatic test_crlf();
    do_reset();
    fifo_ready = 1'b1;
    push(4, 8, 1'b1);
    send_str("4-8\r\n\r\n");
    drain();
    send_str("1-1\n");
    repeat (5) @(negedge clk);
    checks += 3;
    if (done !== 1'b1)       begin errors++; $display("FAIL crlf_done got %0b expected 1", done); end
    if (rec_count !== 16'd1) begin errors++; $display("FAIL crlf_rec_count got %0d expected 1", rec_count); end
    if (err !== 1'b0)        begin errors++; $display("FAIL crlf_err got %0b expected 0", err); end
    $display("test_crlf done");
  endtask

  task automatic test_back_to_back();
    int lo;
    int hi;
    int t;
    logic fr;
    do_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      lo = int'($urandom_range(0, 131071));
      hi = int'($urandom_range(0, 131071));
      if (lo > hi) begin
        t = lo;
        lo = hi;
        hi = t;
      end
      fr = 1'($urandom_range(0, 1));
      push(lo, hi, fr);
      send_str({fr ? "" : "!", $sformatf("%0d-%0d\n", lo, hi)});
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    fifo_ready = 1'b1;
    checks += 2;
    if (rec_count !== 16'd10) begin errors++; $display("FAIL b2b_rec_count got %0d expected 10", rec_count); end
    if (err_count !== 16'd0)  begin errors++; $display("FAIL b2b_err_count got %0d expected 0", err_count); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_errors();
    test_async_reset();
    test_crlf();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
